asg_bst_seq: RTL and testbench
==============================

// Module: asg_bst_seq
// PURPOSE
//  Next-generation burst sequencer for one arbitrary-signal-generator channel.
//  Emits table read addresses as an AXI4-Stream. Per-period burst: (bdl+1) samples, each repeated (bdr+1) times, then idle to end of period.
//  Adds to the previous burst FSM: programmable start address and address step, true backpressure through a registered output stage, and retrigger.
//  Sits between the event/trigger fabric and the table-read/DAC datapath.
// PARAMETERS
//  AW  14  address width (TDATA, cfg_bds, cfg_bst, cfg_bdl)
//  CWR 14  data-repetition counter width
//  CWL 32  period-length counter width
//  CWN 16  period-number counter width
// PORTS
//  sto.ACLK     in   1        clock
//  sto.ARESETn  in   1        reset, asynchronous, active-low
//  sto          axi4_stream_if.s  TDATA[AW] address, TKEEP data-phase, TLAST, TVALID, TREADY
//  evn          in   evn_t    events in: rst, str, stp, swt (software trigger)
//  evs          out  evn_t    status: str=started, swt=running, stp=~str, rst=0
//  ctl_trg      in   1        hardware trigger pulse
//  cfg_tre      in   1        retrigger enable
//  cfg_inf      in   1        infinite periods (ignore cfg_bpn)
//  cfg_bds      in   AW       start address, sampled at run start
//  cfg_bst      in   AW       address step per new sample
//  cfg_bdr      in   CWR      repetitions per sample minus 1
//  cfg_bdl      in   AW       samples per burst minus 1
//  cfg_bpl      in   CWL      period length in beats minus 1
//  cfg_bpn      in   CWN      number of periods minus 1
//  evn_per      out  1        1-cycle pulse: last beat of a period accepted
//  sts_bpl      out  CWL      beat-in-period counter
//  sts_bpn      out  CWN      period counter
// BEHAVIOUR
//  Reset (ARESETn=0, or evn.rst sync, same values): evs.str=0, evs.swt=0, TVALID=0, TKEEP=0, TLAST=0, TDATA=0, counters=0, evn_per=0, trigger mask=1.
//  Priority per cycle: evn.rst > evn.stp > run start > beat advance.
//  run = (evn.swt | (ctl_trg & mask)) & (evs.str | evn.str); simultaneous start+trigger starts.
//  Mask: cleared to cfg_tre on run, set to 1 at run end. cfg_tre=0: triggers ignored while running.
//  Run start: counters=0, adr=cfg_bds, evs.swt=1. First beat has TVALID=1 the next cycle, TDATA=cfg_bds, TKEEP=1.
//  Beat accept = TVALID & TREADY. The output register holds TDATA/TKEEP/TLAST stable while TVALID & ~TREADY. Counters advance only when register empty or accepted.
//  States: IDLE -> DATA (TKEEP=1) -> HOLD (TKEEP=0, TDATA = last address) -> DATA on next period | IDLE on end.
//  Per accepted beat: rep++; at rep==bdr the next sample starts: rep=0, smp++, adr += cfg_bst (mod 2^AW, natural wrap).
//  After sample bdl ends, go to HOLD. bpl++ every beat.
//  At bpl==cfg_bpl: period end. bpl, rep, smp = 0; adr=cfg_bds; bpn++; evn_per pulses the cycle after accept. Period end overrides DATA: the burst is truncated if cfg_bpl is shorter than the burst.
//  Run end: period end with bpn==cfg_bpn & ~cfg_inf. That beat carries TLAST=1. After accept: TVALID=0, evs.swt=0, state IDLE.
//  cfg_inf=1: bpn wraps modulo 2^CWN, no TLAST.
//  evn.stp: evs.str=0 and evs.swt=0 next cycle. TVALID drops at once, with no TLAST. The pending beat is discarded (the generator is lossless-exempt).
//  Retrigger (cfg_tre=1, run while running): the pending unaccepted beat is replaced. The restart beat (adr=cfg_bds) is presented next cycle. No TLAST for the aborted run.
//  cfg_bdr/bdl/bpl/bpn/bst are read live. Changes mid-run take effect at the next comparison.
// TESTING
//  bds=100,bst=2,bdr=1,bdl=2,bpl=9,bpn=1,TREADY=1 -> TDATA 100,100,102,102,104,104 KEEP=1, then 4 idle beats at 104 KEEP=0; repeat; TLAST on beat 20; evn_per on beats 10 and 20.
//  Same config, TREADY toggling 1010... -> identical accepted beat sequence, TDATA stable while stalled, 20 accepts total.
//  bds=0x3FFE,bst=1,bdr=0,bdl=3,AW=14 -> TDATA 3FFE,3FFF,0000,0001 (wrap).
//  cfg_tre=0, ctl_trg again mid-run -> ignored; cfg_tre=1 -> next TDATA=cfg_bds, counters=0, no TLAST.
//  evn.stp at beat 5 -> TVALID=0 next cycle, evs.str=0, no TLAST; evn.rst or ARESETn low mid-run -> all outputs at reset values.
//  cfg_inf=1,bpn=0 -> runs past 3 periods, evn_per each period, TLAST never asserted.

Source files
------------

// File: rtl/asg_bst_seq.sv
// ============================================================================
// Module  : asg_bst_seq
// Purpose : Burst sequencer for one arbitrary-signal-generator channel. Emits
//           table read addresses as an AXI4-Stream with programmable start
//           address, address step, sample repetition, burst length, period
//           length and period count. Supports backpressure and retrigger.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module asg_bst_seq #(
   parameter int AW  = 14,
   parameter int CWR = 14,
   parameter int CWL = 32,
   parameter int CWN = 16
) (
   input  logic           sto_aclk_i,
   input  logic           sto_aresetn_i,
   output logic [AW-1:0]  sto_tdata_o,
   output logic           sto_tkeep_o,
   output logic           sto_tlast_o,
   output logic           sto_tvalid_o,
   input  logic           sto_tready_i,
   input  logic           evn_rst_i,
   input  logic           evn_str_i,
   input  logic           evn_stp_i,
   input  logic           evn_swt_i,
   output logic           evs_rst_o,
   output logic           evs_str_o,
   output logic           evs_stp_o,
   output logic           evs_swt_o,
   input  logic           ctl_trg_i,
   input  logic           cfg_tre_i,
   input  logic           cfg_inf_i,
   input  logic [AW-1:0]  cfg_bds_i,
   input  logic [AW-1:0]  cfg_bst_i,
   input  logic [CWR-1:0] cfg_bdr_i,
   input  logic [AW-1:0]  cfg_bdl_i,
   input  logic [CWL-1:0] cfg_bpl_i,
   input  logic [CWN-1:0] cfg_bpn_i,
   output logic           evn_per_o,
   output logic [CWL-1:0] sts_bpl_o,
   output logic [CWN-1:0] sts_bpn_o
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_DATA = 2'd1,
      ST_HOLD = 2'd2
   } state_t;

   // Counters always describe the beat currently held in the output register.
   state_t         state_q, state_d, state_n;
   logic [CWR-1:0] rep_q, rep_d, rep_n;
   logic [AW-1:0]  smp_q, smp_d, smp_n;
   logic [AW-1:0]  adr_q, adr_d, adr_n;
   logic [CWL-1:0] bpl_q, bpl_d, bpl_n;
   logic [CWN-1:0] bpn_q, bpn_d, bpn_n;
   logic [AW-1:0]  tdata_q, tdata_d;
   logic           tkeep_q, tkeep_d;
   logic           tlast_q, tlast_d;
   logic           tvalid_q, tvalid_d;
   logic           str_q, str_d;
   logic           swt_q, swt_d;
   logic           mask_q, mask_d;
   logic           per_q, per_d;

   logic           accept;
   logic           run;
   logic           pend;
   logic           tlast_n;

   assign accept = tvalid_q & sto_tready_i;
   assign run    = (evn_swt_i | (ctl_trg_i & mask_q)) & (str_q | evn_str_i);
   assign pend   = (bpl_q == cfg_bpl_i);

   // Successor of the presented beat; period end overrides the burst so a
   // short period truncates it.
   always_comb begin
      state_n = state_q;
      rep_n   = rep_q;
      smp_n   = smp_q;
      adr_n   = adr_q;
      bpl_n   = bpl_q + 1'b1;
      bpn_n   = bpn_q;
      if (pend) begin
         state_n = ST_DATA;
         rep_n   = '0;
         smp_n   = '0;
         adr_n   = cfg_bds_i;
         bpl_n   = '0;
         bpn_n   = bpn_q + 1'b1;
      end else if (state_q == ST_DATA) begin
         if (rep_q == cfg_bdr_i) begin
            rep_n = '0;
            if (smp_q == cfg_bdl_i) begin
               state_n = ST_HOLD;
            end else begin
               smp_n = smp_q + 1'b1;
               adr_n = adr_q + cfg_bst_i;
            end
         end else begin
            rep_n = rep_q + 1'b1;
         end
      end
      tlast_n = (bpl_n == cfg_bpl_i) & (bpn_n == cfg_bpn_i) & ~cfg_inf_i;
   end

   // Event priority: reset, stop, run start, then beat advance on accept.
   always_comb begin
      state_d  = state_q;
      rep_d    = rep_q;
      smp_d    = smp_q;
      adr_d    = adr_q;
      bpl_d    = bpl_q;
      bpn_d    = bpn_q;
      tdata_d  = tdata_q;
      tkeep_d  = tkeep_q;
      tlast_d  = tlast_q;
      tvalid_d = tvalid_q;
      str_d    = str_q;
      swt_d    = swt_q;
      mask_d   = mask_q;
      per_d    = 1'b0;
      if (evn_rst_i) begin
         state_d  = ST_IDLE;
         rep_d    = '0;
         smp_d    = '0;
         adr_d    = '0;
         bpl_d    = '0;
         bpn_d    = '0;
         tdata_d  = '0;
         tkeep_d  = 1'b0;
         tlast_d  = 1'b0;
         tvalid_d = 1'b0;
         str_d    = 1'b0;
         swt_d    = 1'b0;
         mask_d   = 1'b1;
      end else if (evn_stp_i) begin
         // The pending beat is dropped without TLAST.
         state_d  = ST_IDLE;
         tkeep_d  = 1'b0;
         tlast_d  = 1'b0;
         tvalid_d = 1'b0;
         str_d    = 1'b0;
         swt_d    = 1'b0;
         mask_d   = 1'b1;
      end else begin
         if (evn_str_i) begin
            str_d = 1'b1;
         end
         if (run) begin
            // Also covers retrigger: any pending beat is overwritten.
            state_d  = ST_DATA;
            rep_d    = '0;
            smp_d    = '0;
            adr_d    = cfg_bds_i;
            bpl_d    = '0;
            bpn_d    = '0;
            tdata_d  = cfg_bds_i;
            tkeep_d  = 1'b1;
            tlast_d  = (cfg_bpl_i == '0) & (cfg_bpn_i == '0) & ~cfg_inf_i;
            tvalid_d = 1'b1;
            swt_d    = 1'b1;
            mask_d   = cfg_tre_i;
         end else if (accept) begin
            per_d = pend;
            rep_d = rep_n;
            smp_d = smp_n;
            adr_d = adr_n;
            bpl_d = bpl_n;
            bpn_d = bpn_n;
            if (tlast_q) begin
               state_d  = ST_IDLE;
               tkeep_d  = 1'b0;
               tlast_d  = 1'b0;
               tvalid_d = 1'b0;
               swt_d    = 1'b0;
               mask_d   = 1'b1;
            end else begin
               state_d  = state_n;
               tdata_d  = adr_n;
               tkeep_d  = (state_n == ST_DATA);
               tlast_d  = tlast_n;
            end
         end
      end
   end

   // State, counter and output-register update.
   always_ff @(posedge sto_aclk_i or negedge sto_aresetn_i) begin
      if (!sto_aresetn_i) begin
         state_q  <= ST_IDLE;
         rep_q    <= '0;
         smp_q    <= '0;
         adr_q    <= '0;
         bpl_q    <= '0;
         bpn_q    <= '0;
         tdata_q  <= '0;
         tkeep_q  <= 1'b0;
         tlast_q  <= 1'b0;
         tvalid_q <= 1'b0;
         str_q    <= 1'b0;
         swt_q    <= 1'b0;
         mask_q   <= 1'b1;
         per_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         rep_q    <= rep_d;
         smp_q    <= smp_d;
         adr_q    <= adr_d;
         bpl_q    <= bpl_d;
         bpn_q    <= bpn_d;
         tdata_q  <= tdata_d;
         tkeep_q  <= tkeep_d;
         tlast_q  <= tlast_d;
         tvalid_q <= tvalid_d;
         str_q    <= str_d;
         swt_q    <= swt_d;
         mask_q   <= mask_d;
         per_q    <= per_d;
      end
   end

   assign sto_tdata_o  = tdata_q;
   assign sto_tkeep_o  = tkeep_q;
   assign sto_tlast_o  = tlast_q;
   assign sto_tvalid_o = tvalid_q;
   assign evs_rst_o    = 1'b0;
   assign evs_str_o    = str_q;
   assign evs_stp_o    = ~str_q;
   assign evs_swt_o    = swt_q;
   assign evn_per_o    = per_q;
   assign sts_bpl_o    = bpl_q;
   assign sts_bpn_o    = bpn_q;

endmodule

`default_nettype wire

// File: tb/tb_asg_bst_seq.sv
// ============================================================================
// Module  : tb_asg_bst_seq
// Purpose : Scoreboard bench for asg_bst_seq. Expected beats are queued when
//           a run is launched and compared against the stream as it appears.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_asg_bst_seq;

   typedef struct packed {
      logic [13:0] adr;
      logic        keep;
      logic        last;
      logic        pend;
   } beat_t;

   logic        clk;
   logic        aresetn;
   logic [13:0] tdata;
   logic        tkeep, tlast, tvalid, tready;
   logic        evn_rst, evn_str, evn_stp, evn_swt;
   logic        evs_rst, evs_str, evs_stp, evs_swt;
   logic        ctl_trg, cfg_tre, cfg_inf;
   logic [13:0] cfg_bds, cfg_bst, cfg_bdl;
   logic [13:0] cfg_bdr;
   logic [31:0] cfg_bpl;
   logic [15:0] cfg_bpn;
   logic        evn_per;
   logic [31:0] sts_bpl;
   logic [15:0] sts_bpn;

   beat_t q[$];
   int    n_chk  = 0;
   int    n_pass = 0;
   int    acc_cnt = 0;
   bit    mon_en = 0;
   logic  exp_per = 1'b0;

   asg_bst_seq dut (
      .sto_aclk_i    (clk),
      .sto_aresetn_i (aresetn),
      .sto_tdata_o   (tdata),
      .sto_tkeep_o   (tkeep),
      .sto_tlast_o   (tlast),
      .sto_tvalid_o  (tvalid),
      .sto_tready_i  (tready),
      .evn_rst_i     (evn_rst),
      .evn_str_i     (evn_str),
      .evn_stp_i     (evn_stp),
      .evn_swt_i     (evn_swt),
      .evs_rst_o     (evs_rst),
      .evs_str_o     (evs_str),
      .evs_stp_o     (evs_stp),
      .evs_swt_o     (evs_swt),
      .ctl_trg_i     (ctl_trg),
      .cfg_tre_i     (cfg_tre),
      .cfg_inf_i     (cfg_inf),
      .cfg_bds_i     (cfg_bds),
      .cfg_bst_i     (cfg_bst),
      .cfg_bdr_i     (cfg_bdr),
      .cfg_bdl_i     (cfg_bdl),
      .cfg_bpl_i     (cfg_bpl),
      .cfg_bpn_i     (cfg_bpn),
      .evn_per_o     (evn_per),
      .sts_bpl_o     (sts_bpl),
      .sts_bpn_o     (sts_bpn)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
   endtask

   // Expected beats: the burst occupies the first (bdl+1)*(bdr+1) beats of a
   // period, then the last sample address is held with KEEP low.
   task automatic push_seq(input int np);
      int nb, idx;
      beat_t e;
      nb = (int'(cfg_bdl) + 1) * (int'(cfg_bdr) + 1);
      for (int p = 0; p < np; p++) begin
         for (int b = 0; b <= int'(cfg_bpl); b++) begin
            idx    = (b < nb) ? b / (int'(cfg_bdr) + 1) : int'(cfg_bdl);
            e.adr  = 14'(int'(cfg_bds) + idx * int'(cfg_bst));
            e.keep = (b < nb);
            e.pend = (b == int'(cfg_bpl));
            e.last = !cfg_inf && (p == int'(cfg_bpn)) && e.pend;
            q.push_back(e);
         end
      end
   endtask

   // Stream monitor: compares every presented beat to the queue head, pops on
   // accept, and expects evn_per the cycle after a period-end accept.
   always @(negedge clk) begin
      if (mon_en) begin
         chk("per", {31'd0, evn_per}, {31'd0, exp_per});
         exp_per = 1'b0;
         if (tvalid) begin
            if (q.size() == 0) begin
               chk("sb_underflow", q.size(), 1);
            end else begin
               chk("beat", {16'd0, tdata, tkeep, tlast}, {16'd0, q[0].adr, q[0].keep, q[0].last});
               if (tready) begin
                  exp_per = q[0].pend;
                  void'(q.pop_front());
                  acc_cnt++;
               end
            end
         end
      end else begin
         exp_per = 1'b0;
      end
   end

   task automatic start_run(input bit via_trg, input int np);
      @(posedge clk); #1;
      acc_cnt = 0;
      q.delete();
      push_seq(np);
      evn_str = 1'b1;
      if (via_trg) ctl_trg = 1'b1;
      else evn_swt = 1'b1;
      mon_en = 1;
      @(posedge clk); #1;
      evn_str = 1'b0;
      ctl_trg = 1'b0;
      evn_swt = 1'b0;
   endtask

   task automatic wait_acc(input int n, input int budget, input bit tog);
      for (int i = 0; i < budget && acc_cnt < n; i++) begin
         @(posedge clk); #1;
         if (tog) tready = ~tready;
      end
      if (acc_cnt < n) chk("timeout", acc_cnt, n);
   endtask

   task automatic set_cfg(input int bds, input int bst, input int bdr, input int bdl,
                          input int bpl, input int bpn);
      cfg_bds = 14'(bds);
      cfg_bst = 14'(bst);
      cfg_bdr = 14'(bdr);
      cfg_bdl = 14'(bdl);
      cfg_bpl = 32'(bpl);
      cfg_bpn = 16'(bpn);
   endtask

   task automatic check_idle_end(input string tag, input int nacc, input int bpn);
      chk({tag, "_acc"}, acc_cnt, nacc);
      chk({tag, "_tvalid"}, {31'd0, tvalid}, 0);
      chk({tag, "_swt"}, {31'd0, evs_swt}, 0);
      chk({tag, "_bpn"}, {16'd0, sts_bpn}, bpn);
      chk({tag, "_qleft"}, q.size(), 0);
   endtask

   initial begin
      aresetn = 1'b0;
      tready  = 1'b1;
      evn_rst = 1'b0; evn_str = 1'b0; evn_stp = 1'b0; evn_swt = 1'b0;
      ctl_trg = 1'b0; cfg_tre = 1'b0; cfg_inf = 1'b0;
      set_cfg(100, 2, 1, 2, 9, 1);
      repeat (3) @(posedge clk);
      #2 aresetn = 1'b1;

      // Reset state
      @(negedge clk);
      chk("rst_tvalid", {31'd0, tvalid}, 0);
      chk("rst_tdata", {18'd0, tdata}, 0);
      chk("rst_tkeep_tlast", {30'd0, tkeep, tlast}, 0);
      chk("rst_evs", {28'd0, evs_rst, evs_str, evs_stp, evs_swt}, 32'b0010);
      chk("rst_sts", {sts_bpl[15:0], sts_bpn}, 0);
      chk("rst_per", {31'd0, evn_per}, 0);

      // Basic burst, full-rate sink, start and software trigger together
      start_run(0, 2);
      chk("run_swt", {31'd0, evs_swt}, 1);
      wait_acc(20, 200, 0);
      check_idle_end("burst", 20, 2);

      // Same config with a stalling sink
      start_run(0, 2);
      wait_acc(20, 200, 1);
      tready = 1'b1;
      @(posedge clk); #1;
      check_idle_end("stall", 20, 2);

      // Address wrap, launched by hardware trigger
      set_cfg(14'h3FFE, 1, 0, 3, 3, 0);
      start_run(1, 1);
      wait_acc(4, 100, 0);
      check_idle_end("wrap", 4, 1);

      // Retrigger disabled: mid-run trigger is ignored
      set_cfg(200, 2, 1, 2, 9, 1);
      start_run(1, 2);
      wait_acc(4, 100, 0);
      ctl_trg = 1'b1;
      @(posedge clk); #1;
      ctl_trg = 1'b0;
      wait_acc(20, 200, 0);
      check_idle_end("noretrig", 20, 2);

      // Retrigger enabled: restart at cfg_bds with counters cleared
      cfg_tre = 1'b1;
      set_cfg(50, 3, 0, 1, 5, 0);
      start_run(1, 1);
      wait_acc(3, 100, 0);
      tready  = 1'b0;
      ctl_trg = 1'b1;
      @(posedge clk); #1;
      ctl_trg = 1'b0;
      tready  = 1'b1;
      q.delete();
      push_seq(1);
      acc_cnt = 0;
      chk("retrig_bpl", sts_bpl, 0);
      chk("retrig_bpn", {16'd0, sts_bpn}, 0);
      wait_acc(6, 100, 0);
      check_idle_end("retrig", 6, 1);
      cfg_tre = 1'b0;

      // Stop mid-run
      set_cfg(100, 2, 1, 2, 9, 1);
      start_run(0, 2);
      wait_acc(5, 100, 0);
      tready  = 1'b0;
      evn_stp = 1'b1;
      @(posedge clk); #1;
      evn_stp = 1'b0;
      mon_en  = 0;
      q.delete();
      tready  = 1'b1;
      chk("stp_tvalid", {31'd0, tvalid}, 0);
      chk("stp_tlast", {31'd0, tlast}, 0);
      chk("stp_evs", {29'd0, evs_str, evs_stp, evs_swt}, 32'b010);
      repeat (3) @(posedge clk);
      #1 chk("stp_still_idle", {31'd0, tvalid}, 0);

      // Synchronous event reset mid-run
      start_run(0, 2);
      wait_acc(3, 100, 0);
      evn_rst = 1'b1;
      mon_en  = 0;
      @(posedge clk); #1;
      evn_rst = 1'b0;
      q.delete();
      chk("erst_out", {14'd0, tdata, tkeep, tlast, tvalid, evn_per}, 0);
      chk("erst_evs", {29'd0, evs_str, evs_stp, evs_swt}, 32'b010);
      chk("erst_sts", {sts_bpl[15:0], sts_bpn}, 0);

      // Asynchronous reset mid-run
      start_run(0, 2);
      wait_acc(3, 100, 0);
      aresetn = 1'b0;
      mon_en  = 0;
      #2;
      q.delete();
      chk("arst_out", {14'd0, tdata, tkeep, tlast, tvalid, evn_per}, 0);
      chk("arst_evs", {29'd0, evs_str, evs_stp, evs_swt}, 32'b010);
      chk("arst_sts", {sts_bpl[15:0], sts_bpn}, 0);
      @(negedge clk);
      aresetn = 1'b1;

      // Infinite periods: no TLAST, evn_per every period
      cfg_inf = 1'b1;
      set_cfg(7, 1, 0, 1, 4, 0);
      start_run(0, 4);
      wait_acc(15, 200, 0);
      chk("inf_bpn", {16'd0, sts_bpn}, 3);
      chk("inf_running", {31'd0, evs_swt}, 1);
      tready  = 1'b0;
      evn_stp = 1'b1;
      @(posedge clk); #1;
      evn_stp = 1'b0;
      mon_en  = 0;
      q.delete();
      tready  = 1'b1;
      cfg_inf = 1'b0;
      chk("inf_stop", {31'd0, tvalid}, 0);

      repeat (2) @(posedge clk);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule

`default_nettype wire
